// File: rtl/tx_sched_pkg.sv
// tx_sched_pkg: shared widths, requester indices and FSM states for the TX scheduler.
package tx_sched_pkg;
  localparam int AW = 11;
  localparam int CW = 16;
  localparam int NREQ = 2;
  localparam int REQ_ADC = 0;
  localparam int REQ_STS = 1;
  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_SEND, ST_GAP} state_t;
endpackage

// File: rtl/tx_sched_if.sv
// tx_sched_if: requester/TX-engine side signals of the scheduler.
import tx_sched_pkg::*;

interface tx_sched_if;
  logic [NREQ-1:0] req;
  logic [AW-1:0] base0;
  logic [AW-1:0] base1;
  logic done;
  logic [NREQ-1:0] grant;
  logic start;
  logic [AW-1:0] txbase;
  logic [AW-1:0] txlen;
  logic [NREQ-1:0] ack;
  logic err;
  logic [CW-1:0] fcnt0;
  logic [CW-1:0] fcnt1;
  modport master (input req, base0, base1, done,
                  output grant, start, txbase, txlen, ack, err, fcnt0, fcnt1);
  modport slave (output req, base0, base1, done,
                 input grant, start, txbase, txlen, ack, err, fcnt0, fcnt1);
endinterface

// File: rtl/tx_sched_cyc_timer.sv
// cyc_timer: loadable down-counter that stops at zero and flags expiry.
module cyc_timer #(
  parameter int W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic [W-1:0] val,
  output logic expired
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= val;
    else if (cnt != '0) cnt <= cnt - W'(1);
  assign expired = cnt == '0;
endmodule

// File: rtl/tx_sched.sv
// tx_sched: round-robin arbiter launching fixed-length frames into the TX engine with timeout and inter-frame gap.
import tx_sched_pkg::*;

module tx_sched #(
  parameter int FRAME_LEN = 1024,
  parameter int GAP = 12,
  parameter int TIMEOUT = 4096
) (
  input logic clk125,
  input logic reset,
  tx_sched_if.master bus
);
  state_t state, state_n;
  logic last, last_n, win;
  logic [NREQ-1:0] grant_n, ack_n;
  logic start_n, err_n, gap_exp, to_exp;
  logic [AW-1:0] txbase_n;
  logic [CW-1:0] cnt0, cnt1;
  // last holds the requester granted most recently; ties go to the other one
  always_comb begin
    win = bus.req[REQ_STS] & (~bus.req[REQ_ADC] | ~last);
    state_n = state;
    last_n = last;
    grant_n = bus.grant;
    txbase_n = bus.txbase;
    start_n = 1'b0;
    ack_n = '0;
    err_n = 1'b0;
    case (state)
      ST_IDLE: if (bus.req != '0) begin
        state_n = ST_GRANT;
        last_n = win;
        grant_n = win ? 2'b10 : 2'b01;
        txbase_n = win ? bus.base1 : bus.base0;
        start_n = 1'b1;
      end
      ST_GRANT: state_n = ST_SEND;
      ST_SEND: if (bus.done || to_exp) begin
        state_n = ST_GAP;
        grant_n = '0;
        ack_n = bus.done ? bus.grant : '0;
        err_n = ~bus.done;
      end
      ST_GAP: state_n = gap_exp ? ST_IDLE : ST_GAP;
      default: state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk125 or posedge reset)
    if (reset) begin
      state <= ST_IDLE;
      last <= 1'b1;
      bus.grant <= '0;
      bus.start <= 1'b0;
      bus.txbase <= '0;
      bus.ack <= '0;
      bus.err <= 1'b0;
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      state <= state_n;
      last <= last_n;
      bus.grant <= grant_n;
      bus.start <= start_n;
      bus.txbase <= txbase_n;
      bus.ack <= ack_n;
      bus.err <= err_n;
      if (ack_n[REQ_ADC]) cnt0 <= cnt0 + CW'(1);
      if (ack_n[REQ_STS]) cnt1 <= cnt1 + CW'(1);
    end
  assign bus.txlen = AW'(FRAME_LEN);
  assign bus.fcnt0 = cnt0;
  assign bus.fcnt1 = cnt1;
  cyc_timer #(.W(16)) u_to (
    .clk(clk125), .rst(reset), .load(start_n), .val(16'(TIMEOUT)), .expired(to_exp)
  );
  cyc_timer #(.W(8)) u_gap (
    .clk(clk125), .rst(reset), .load(state == ST_SEND && state_n == ST_GAP),
    .val(8'(GAP)), .expired(gap_exp)
  );
endmodule

// File: tb/tb_tx_sched.sv
// tb_tx_sched: directed bench for tx_sched; "cycle k" is the interval after rising edge k.
module tb_tx_sched;
  logic clk125 = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int n;
  localparam logic [10:0] B0 = 11'h100;
  localparam logic [10:0] B1 = 11'h2A5;
  tx_sched_if bus ();
  tx_sched dut (.clk125(clk125), .reset(reset), .bus(bus));
  always #5 clk125 = ~clk125;
  task automatic tick();
    @(posedge clk125);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_start(output int cnt);
    cnt = 0;
    while (bus.start !== 1'b1 && cnt < 60) begin
      tick();
      cnt++;
    end
    chk("start_seen", {31'b0, bus.start}, 32'd1);
  endtask
  task automatic run_frame(input logic [1:0] r, input logic [1:0] g, input logic [10:0] b);
    int c;
    bus.req = r;
    wait_start(c);
    chk("frame_grant", bus.grant, g);
    chk("frame_base", bus.txbase, b);
    chk("frame_len", bus.txlen, 32'd1024);
    tick();
    tick();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    chk("frame_ack", bus.ack, g);
  endtask
  initial begin
    bus.req = '0;
    bus.base0 = B0;
    bus.base1 = B1;
    bus.done = 1'b0;
    tick();
    tick();
    chk("rst_grant", bus.grant, 0);
    chk("rst_start", bus.start, 0);
    chk("rst_txbase", bus.txbase, 0);
    chk("rst_ack_err", {bus.ack, bus.err}, 0);
    chk("rst_fcnt", {bus.fcnt0, bus.fcnt1}, 0);
    reset = 1'b0;
    bus.req = 2'b01;
    tick();
    chk("c1_start", bus.start, 1);
    chk("c1_grant", bus.grant, 2'b01);
    chk("c1_txbase", bus.txbase, B0);
    chk("c1_txlen", bus.txlen, 32'd1024);
    bus.req = 2'b00;
    tick();
    chk("c2_start", bus.start, 0);
    for (int i = 3; i <= 20; i++) tick();
    chk("c20_grant_held", bus.grant, 2'b01);
    chk("c20_ack", bus.ack, 0);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    chk("c21_ack", bus.ack, 2'b01);
    chk("c21_grant", bus.grant, 0);
    chk("c21_fcnt0", bus.fcnt0, 1);
    chk("c21_err", bus.err, 0);
    tick();
    chk("c22_ack", bus.ack, 0);
    bus.req = 2'b01;
    for (int i = 23; i <= 34; i++) begin
      tick();
      bus.done = (i == 25);
      chk("gap_start", bus.start, 0);
      chk("gap_ack", bus.ack, 0);
    end
    chk("gap_fcnt0", bus.fcnt0, 1);
    tick();
    chk("c35_start", bus.start, 1);
    chk("c35_grant", bus.grant, 2'b01);
    bus.req = 2'b11;
    tick();
    tick();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    chk("rr1_ack", bus.ack, 2'b01);
    run_frame(2'b11, 2'b10, B1);
    run_frame(2'b11, 2'b01, B0);
    run_frame(2'b11, 2'b10, B1);
    chk("rr_fcnt0", bus.fcnt0, 3);
    chk("rr_fcnt1", bus.fcnt1, 2);
    bus.req = 2'b10;
    wait_start(n);
    chk("to_grant", bus.grant, 2'b10);
    bus.req = 2'b00;
    for (int i = 0; i < 4096; i++) tick();
    chk("to_early_err", bus.err, 0);
    chk("to_early_grant", bus.grant, 2'b10);
    tick();
    chk("to_err", bus.err, 1);
    chk("to_ack", bus.ack, 0);
    chk("to_grant_off", bus.grant, 0);
    chk("to_fcnt1", bus.fcnt1, 2);
    tick();
    chk("to_err_pulse", bus.err, 0);
    bus.req = 2'b01;
    wait_start(n);
    chk("to_gap_len", n, 13);
    bus.req = 2'b00;
    for (int i = 0; i < 4096; i++) tick();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    chk("tie_ack", bus.ack, 2'b01);
    chk("tie_err", bus.err, 0);
    chk("tie_fcnt0", bus.fcnt0, 4);
    force dut.cnt0 = 16'hFFFF;
    #1;
    release dut.cnt0;
    chk("wrap_pre", bus.fcnt0, 16'hFFFF);
    run_frame(2'b01, 2'b01, B0);
    chk("wrap_fcnt0", bus.fcnt0, 0);
    chk("wrap_fcnt1", bus.fcnt1, 2);
    bus.req = 2'b00;
    for (int i = 0; i < 20; i++) tick();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    chk("idle_done_ack", bus.ack, 0);
    tick();
    chk("idle_done_ack2", bus.ack, 0);
    chk("idle_done_cnt", {bus.fcnt0, bus.fcnt1}, {16'h0, 16'h2});
    chk("idle_done_start", bus.start, 0);
    bus.req = 2'b11;
    wait_start(n);
    chk("rs_grant", bus.grant, 2'b10);
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("rs_grant_clr", bus.grant, 0);
    chk("rs_txbase_clr", bus.txbase, 0);
    chk("rs_fcnt_clr", {bus.fcnt0, bus.fcnt1}, 0);
    chk("rs_ack_err", {bus.ack, bus.err}, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("rs_first_start", bus.start, 1);
    chk("rs_first_grant", bus.grant, 2'b01);
    chk("rs_first_base", bus.txbase, B0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tx_sched.md
TX_SCHED -- requirements
Module: tx_sched

Interface
REQ-001 Parameter FRAME_LEN, default 1024, frame length in bytes passed to the TX engine (11-bit).
REQ-002 Parameter GAP, default 12, idle clk125 cycles enforced between frames (1..255).
REQ-003 Parameter TIMEOUT, default 4096, maximum clk125 cycles to wait for done after start (16-bit).
REQ-004 clk125  in  1  sole clock; all logic on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req  in  2  level request per requester (bit0 ADC data frame, bit1 status frame).
REQ-007 base0  in  11  ad2tx buffer base address for requester 0.
REQ-008 base1  in  11  ad2tx buffer base address for requester 1.
REQ-009 done  in  1  one-cycle pulse from TX engine: frame fully sent.
REQ-010 grant  out  2  one-hot (or zero) owner of the TX engine.
REQ-011 start  out  1  one-cycle pulse launching a frame.
REQ-012 txbase  out  11  base address of the granted frame; stable from start until done or abort.
REQ-013 txlen  out  11  equals FRAME_LEN whenever start is high.
REQ-014 ack  out  2  one-cycle pulse to the requester whose frame completed.
REQ-015 err  out  1  one-cycle pulse on timeout abort.
REQ-016 fcnt0, fcnt1  out  16 each  completed-frame counters, wrap 0xFFFF->0.

Function
REQ-017 FSM states: IDLE, GRANT, SEND, GAP; all outputs registered.
REQ-018 IDLE: req!=0 sampled at edge n -> GRANT at n+1; else stay IDLE.
REQ-019 Arbitration round-robin: single request wins; both requested -> requester not granted last wins.
REQ-020 GRANT lasts exactly one cycle: grant one-hot set, start=1, txbase latched from winner's base; next state SEND.
REQ-021 SEND: grant held; done=1 -> ack[owner]=1 next cycle, fcnt[owner] increments, state GAP.
REQ-022 SEND: timeout counter reaching TIMEOUT without done -> err=1 one cycle, no ack, no count, state GAP.
REQ-023 GAP: grant=0; counts GAP cycles then IDLE; requests ignored during GAP.
REQ-024 done outside SEND ignored (no ack, no count, no state change).
REQ-025 Request deasserted while granted does not abort; frame completes and ack still issued.
REQ-026 done and timeout expiry in same cycle: done wins (ack, no err).
REQ-027 Round-robin pointer updates at GRANT, including frames later aborted.
REQ-028 Minimum req-to-req frame period = 1 (IDLE) + 1 (GRANT) + send cycles + GAP.

Reset
REQ-029 reset asserted in any state: state IDLE, grant=0, start=0, ack=0, err=0, txbase=0, fcnt0=fcnt1=0, timers cleared, pointer set so requester 0 wins first tie.
REQ-030 Reset mid-frame issues no ack and no err; first decision occurs on the first edge after release.

Structure
REQ-031 Package tx_sched_pkg holds state enum, address/count width constants, and requester index constants.
REQ-032 One sub-module cyc_timer (loadable down-counter with expiry flag), instantiated for both the gap and timeout counts.

Verification
REQ-033 req=01 at cycle 0, done at cycle 20 -> start and grant=01 at cycle 1, txbase=base0, ack=01 at 21, fcnt0=1, grant=0 at 21, next start not before cycle 35 (GAP=12).
REQ-034 req=11 held -> grants alternate 01,10,01,10 across four frames, each acked.
REQ-035 req=10, no done for 4096 cycles -> err pulse one cycle, ack=00, fcnt1 unchanged, FSM returns IDLE after GAP.
REQ-036 done pulse while IDLE or GAP -> no ack, counters unchanged.
REQ-037 Reset asserted during SEND -> outputs cleared immediately; after release req=11 grants requester 0 first.
REQ-038 fcnt0 preset near 0xFFFF via 65536 frames (or forced) -> wraps to 0 on the next ack.
